// File: rtl/ray_dir_gen.sv
// ray_dir_gen: raster-order primary-ray direction generator.
// Walks the image plane one pixel per cycle while downstream credit is
// available and emits a pixel-centred camera-space direction {x, y, z}
// together with a one-cycle write strobe for the ray-direction FIFO.

`ifndef WIDTH
`define WIDTH 16
`endif

module ray_dir_gen #(
  parameter int WIDTH   = `WIDTH,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int FOCAL   = 512,
  parameter int CREDITS = 20,
  localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_in,
  input  logic                 pop_in,
  output logic                 write_out,
  output logic [3*WIDTH-1:0]   RD_out,
  output logic [XW-1:0]        pixel_x_out,
  output logic [YW-1:0]        pixel_y_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 credit_err_out
);

  // Direction arithmetic runs two bits wider than the output so that the
  // intermediate 2*p term cannot overflow before truncation.
  localparam int AW = WIDTH + 2;
  localparam int CW = (CREDITS > 0) ? $clog2(CREDITS + 1) : 1;

  localparam logic [XW-1:0]        X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]        Y_LAST  = YW'(IMG_H - 1);
  localparam logic [CW-1:0]        C_FULL  = CW'(CREDITS);
  localparam logic [CW-1:0]        C_ONE_C = CW'(1);
  localparam logic signed [AW-1:0] C_IMG_W = AW'(IMG_W);
  localparam logic signed [AW-1:0] C_IMG_H = AW'(IMG_H);
  localparam logic signed [AW-1:0] C_ONE   = AW'(1);
  localparam logic [WIDTH-1:0]     C_Z     = WIDTH'(-FOCAL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [XW-1:0]       r_px;
  logic [YW-1:0]       r_py;
  logic [CW-1:0]       r_credits;
  logic                r_credit_err;
  logic                w_emit;
  logic                w_last;
  logic                w_full;
  logic signed [AW-1:0] w_px_s;
  logic signed [AW-1:0] w_py_s;
  logic [WIDTH-1:0]    w_dir_x;
  logic [WIDTH-1:0]    w_dir_y;

  // An emit only uses credit that was already registered; a same-cycle
  // pop cannot enable it.
  assign w_emit = (r_state == S_RUN) && (r_credits != '0);
  assign w_last = (r_px == X_LAST) && (r_py == Y_LAST);
  assign w_full = (r_credits == C_FULL);

  assign w_px_s  = AW'(r_px);
  assign w_py_s  = AW'(r_py);
  assign w_dir_x = WIDTH'((w_px_s <<< 1) + C_ONE - C_IMG_W);
  assign w_dir_y = WIDTH'(C_IMG_H - (w_py_s <<< 1) - C_ONE);

  assign busy_out       = (r_state != S_IDLE);
  assign done_out       = (r_state == S_DONE);
  assign credit_err_out = r_credit_err;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: DONE is a single-cycle state so done_out lines up
  // with the write strobe of the final pixel.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_state_next = S_RUN;
      S_RUN:   if (w_emit && w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Raster position: cleared on frame start, advanced on every emit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_px <= '0;
      r_py <= '0;
    end else if ((r_state == S_IDLE) && start_in) begin
      r_px <= '0;
      r_py <= '0;
    end else if (w_emit) begin
      if (r_px == X_LAST) begin
        r_px <= '0;
        r_py <= (r_py == Y_LAST) ? '0 : r_py + YW'(1);
      end else begin
        r_px <= r_px + XW'(1);
      end
    end
  end

  // Credit counter survives frame boundaries so late pops from the previous
  // frame still return credit; a pop with every credit home is flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits    <= C_FULL;
      r_credit_err <= 1'b0;
    end else begin
      if (pop_in && w_full) begin
        r_credit_err <= 1'b1;
      end
      case ({w_emit, pop_in})
        2'b10:   r_credits <= r_credits - C_ONE_C;
        2'b01:   if (!w_full) r_credits <= r_credits + C_ONE_C;
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Output registers: direction and pixel ports hold between emits.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_out   <= 1'b0;
      RD_out      <= '0;
      pixel_x_out <= '0;
      pixel_y_out <= '0;
    end else begin
      write_out <= w_emit;
      if (w_emit) begin
        RD_out      <= {w_dir_x, w_dir_y, C_Z};
        pixel_x_out <= r_px;
        pixel_y_out <= r_py;
      end
    end
  end

endmodule

// File: tb/tb_ray_dir_gen.sv
// Bench for ray_dir_gen with a small 4x2 image: a transaction-level model
// checks every cycle, directed scenarios pin counts, latency and literals.

module tb_ray_dir_gen;

  localparam int WIDTH   = 16;
  localparam int IMG_W   = 4;
  localparam int IMG_H   = 2;
  localparam int FOCAL   = 8;
  localparam int CREDITS = 3;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam int XW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start_in = 1'b0;
  logic                pop_in = 1'b0;
  logic                write_out;
  logic [3*WIDTH-1:0]  RD_out;
  logic [XW-1:0]       pixel_x_out;
  logic [YW-1:0]       pixel_y_out;
  logic                busy_out;
  logic                done_out;
  logic                credit_err_out;

  ray_dir_gen #(
    .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .FOCAL(FOCAL), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .reset(reset), .start_in(start_in), .pop_in(pop_in),
    .write_out(write_out), .RD_out(RD_out),
    .pixel_x_out(pixel_x_out), .pixel_y_out(pixel_y_out),
    .busy_out(busy_out), .done_out(done_out), .credit_err_out(credit_err_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Inputs as seen by the DUT at each rising edge.
  logic in_reset = 1'b1;
  logic in_pop   = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    in_reset <= reset;
    in_pop   <= pop_in;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] exp_rd(input int px, input int py);
    int x;
    int y;
    int z;
    x = 2 * px + 1 - IMG_W;
    y = IMG_H - 2 * py - 1;
    z = -FOCAL;
    return {x[15:0], y[15:0], z[15:0]};
  endfunction

  // Model state: position in the frame's pixel stream, outstanding credit,
  // sticky error, last emitted values, and a log of every write.
  int          m_idx = 0;
  int          m_cred = CREDITS;
  bit          m_err = 1'b0;
  logic [47:0] m_last_rd = '0;
  int          m_last_x = 0;
  int          m_last_y = 0;
  int          m_px;
  int          m_py;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  int          log_x [0:127];
  int          log_y [0:127];
  int          log_cyc [0:127];
  logic [47:0] log_rd [0:127];

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (in_reset) begin
      m_idx = 0; m_cred = CREDITS; m_err = 1'b0;
      m_last_rd = '0; m_last_x = 0; m_last_y = 0;
      check("rst_write", write_out, 0);
      check("rst_rd", RD_out, 0);
      check("rst_px", pixel_x_out, 0);
      check("rst_py", pixel_y_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
      check("rst_err", credit_err_out, 0);
    end else begin
      if (write_out === 1'b1) begin
        m_px = m_idx % IMG_W;
        m_py = m_idx / IMG_W;
        check("credit_avail", (m_cred > 0), 1);
        check("wr_px", pixel_x_out, m_px);
        check("wr_py", pixel_y_out, m_py);
        check("wr_rd", RD_out, exp_rd(m_px, m_py));
        check("wr_done", done_out, (m_idx == NPIX - 1));
        check("wr_busy", busy_out, 1);
        if (wr_cnt < 128) begin
          log_x[wr_cnt] = pixel_x_out;
          log_y[wr_cnt] = pixel_y_out;
          log_rd[wr_cnt] = RD_out;
          log_cyc[wr_cnt] = cyc;
        end
        $display("[TB] write #%0d cyc=%0d px=%0d py=%0d rd=%h done=%0b",
                 wr_cnt, cyc, pixel_x_out, pixel_y_out, RD_out, done_out);
        if (done_out === 1'b1) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        wr_cnt++;
        m_last_rd = exp_rd(m_px, m_py);
        m_last_x = m_px;
        m_last_y = m_py;
        m_idx = (m_idx + 1) % NPIX;
      end else begin
        check("hold_rd", RD_out, m_last_rd);
        check("hold_px", pixel_x_out, m_last_x);
        check("hold_py", pixel_y_out, m_last_y);
        check("idle_done", done_out, 0);
      end
      if (in_pop && m_cred == CREDITS) m_err = 1'b1;
      if (write_out === 1'b1 && !in_pop) m_cred--;
      else if (write_out !== 1'b1 && in_pop && m_cred < CREDITS) m_cred++;
      check("credit_err", credit_err_out, m_err);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
  endtask

  int base;
  int dbase;
  int s_cyc;
  bit seen;

  initial begin
    // Reset
    reset = 1'b1;
    step(3);
    check("t0_busy", busy_out, 0);
    check("t0_rd", RD_out, 0);
    reset = 1'b0;
    step(1);

    // 1: full frame with pop every cycle
    pop_in = 1'b1;
    base = wr_cnt; dbase = done_cnt; s_cyc = cyc;
    pulse_start();
    step(13);
    check("t1_writes", wr_cnt - base, 8);
    check("t1_dones", done_cnt - dbase, 1);
    check("t1_busy_after", busy_out, 0);
    check("t1_latency", log_cyc[base], s_cyc + 2);
    check("t1_consecutive", log_cyc[base + 7] - log_cyc[base], 7);
    check("t1_first_rd", log_rd[base], 48'hFFFD_0001_FFF8);
    check("t1_px3_rd", log_rd[base + 3], 48'h0003_0001_FFF8);
    check("t1_last_rd", log_rd[base + 7], 48'h0003_FFFF_FFF8);
    check("t1_done_with_last", last_done_cyc, log_cyc[base + 7]);

    // 2: no pops -> credit stall after 3 writes, one pop -> one write
    pop_in = 1'b0;
    step(1);
    base = wr_cnt;
    pulse_start();
    step(12);
    check("t2_writes", wr_cnt - base, 3);
    check("t2_stalled", write_out, 0);
    check("t2_busy", busy_out, 1);
    check("t2_third_px", log_x[base + 2], 2);
    pop_in = 1'b1;
    step(1);
    pop_in = 1'b0;
    step(6);
    check("t2_one_more", wr_cnt - base, 4);
    check("t2_fourth_px", log_x[base + 3], 3);
    check("t2_fourth_rd", log_rd[base + 3], 48'h0003_0001_FFF8);
    check("t2_stalled_again", write_out, 0);

    // 3: pops at full credit -> sticky error, credits stay saturated
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    pop_in = 1'b1;
    step(3);
    pop_in = 1'b0;
    check("t3_err", credit_err_out, 1);
    step(1);
    base = wr_cnt;
    pulse_start();
    step(10);
    check("t3_writes", wr_cnt - base, 3);
    check("t3_stalled", write_out, 0);
    check("t3_err_sticky", credit_err_out, 1);

    // 4: start during RUN is ignored
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    pop_in = 1'b1;
    base = wr_cnt; dbase = done_cnt;
    pulse_start();
    step(3);
    start_in = 1'b1;
    step(2);
    start_in = 1'b0;
    step(10);
    check("t4_writes", wr_cnt - base, 8);
    check("t4_dones", done_cnt - dbase, 1);
    check("t4_busy", busy_out, 0);

    // 5: reset after the 5th write
    base = wr_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (wr_cnt - base >= 5) seen = 1'b1;
    end
    check("t5_reached_5", seen, 1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("t5_write", write_out, 0);
    check("t5_busy", busy_out, 0);
    check("t5_rd", RD_out, 0);
    check("t5_count", wr_cnt - base, 5);
    reset = 1'b0;
    base = wr_cnt;
    pulse_start();
    step(4);
    check("t5_restart_px", log_x[base], 0);
    check("t5_restart_py", log_y[base], 0);
    check("t5_restart_rd", log_rd[base], 48'hFFFD_0001_FFF8);
    step(10);

    // 6: back-to-back frames
    base = wr_cnt; dbase = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_out === 1'b1) seen = 1'b1;
    end
    check("t6_first_done", seen, 1);
    @(posedge clk);
    #1;
    pulse_start();
    step(14);
    check("t6_writes", wr_cnt - base, 16);
    check("t6_dones", done_cnt - dbase, 2);
    check("t6_busy", busy_out, 0);
    for (int i = 0; i < NPIX; i++) begin
      check("t6_repeat_x", log_x[base + 8 + i], log_x[base + i]);
      check("t6_repeat_y", log_y[base + 8 + i], log_y[base + i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
